// File: rtl/systolic_array_ws.sv
// rtl/systolic_array_ws.sv - weight-stationary ROWS x COLS systolic MAC array with skew, de-skew and control FSM
// Optional macro SA_SATURATE_EN: saturating partial-sum adds instead of two's-complement wrap.
module systolic_array_ws #(
   parameter int ROWS   = 3,
   parameter int COLS   = 3,
   parameter int DATA_W = 8,
   parameter int ACC_W  = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wt_valid,
   output logic                    wt_ready,
   input  logic [COLS*DATA_W-1:0]  wt_data,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [ROWS*DATA_W-1:0]  in_data,
   input  logic                    in_last,
   output logic                    out_valid,
   output logic [COLS*ACC_W-1:0]   out_data,
   output logic                    out_last,
   output logic                    busy
);

   localparam int L  = ROWS + COLS;
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int CW = $clog2(L + 1);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ARMED, S_STREAM, S_DRAIN} state_e;

   state_e                   state_q, state_d;
   logic [RW-1:0]            row_q, row_d, wt_row;
   logic [CW-1:0]            cnt_q, cnt_d;
   logic                     wt_we, accept;
   logic [L:0]               vld_q, last_q;
   logic [COLS*ACC_W-1:0]    out_q;

   logic signed [DATA_W-1:0] skew_out [ROWS];
   logic signed [DATA_W-1:0] act_w    [ROWS][COLS];
   logic signed [ACC_W-1:0]  psum_w   [ROWS][COLS];
   logic signed [ACC_W-1:0]  col_out  [COLS];

   function automatic logic signed [ACC_W-1:0] add_acc(input logic signed [ACC_W-1:0] a,
                                                       input logic signed [ACC_W-1:0] b);
`ifdef SA_SATURATE_EN
      logic signed [ACC_W:0] s;
      s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
      if (s[ACC_W] != s[ACC_W-1])
         return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      return s[ACC_W-1:0];
`else
      return a + b;
`endif
   endfunction

   // Weight beats take priority over activation beats whenever both handshakes are open.
   always_comb begin
      state_d  = state_q;
      row_d    = row_q;
      cnt_d    = cnt_q;
      wt_ready = 1'b0;
      in_ready = 1'b0;
      busy     = 1'b0;
      wt_we    = 1'b0;
      accept   = 1'b0;
      wt_row   = row_q;
      case (state_q)
         S_IDLE: begin
            wt_ready = 1'b1;
            wt_row   = '0;
         end
         S_LOAD: begin
            wt_ready = 1'b1;
            busy     = 1'b1;
         end
         S_ARMED: begin
            wt_ready = 1'b1;
            in_ready = !wt_valid;
            wt_row   = '0;
         end
         S_STREAM: begin
            in_ready = 1'b1;
            busy     = 1'b1;
         end
         S_DRAIN: begin
            busy = 1'b1;
            if (cnt_q == CW'(L - 1)) begin
               state_d = S_ARMED;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (wt_ready && wt_valid) begin
         wt_we = 1'b1;
         if (wt_row == RW'(ROWS - 1)) begin
            state_d = S_ARMED;
            row_d   = '0;
         end else begin
            state_d = S_LOAD;
            row_d   = wt_row + RW'(1);
         end
      end else if (in_ready && in_valid) begin
         accept = 1'b1;
         if (in_last) begin
            state_d = S_DRAIN;
            cnt_d   = '0;
         end else begin
            state_d = S_STREAM;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         row_q   <= '0;
         cnt_q   <= '0;
         vld_q   <= '0;
         last_q  <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         cnt_q   <= cnt_d;
         vld_q   <= {vld_q[L-1:0], accept};
         last_q  <= {last_q[L-1:0], accept & in_last};
         if (vld_q[L-1]) begin
            for (int c = 0; c < COLS; c++)
               out_q[c*ACC_W +: ACC_W] <= col_out[c];
         end
      end
   end

   for (genvar r = 0; r < ROWS; r++) begin : g_skew
      logic signed [DATA_W-1:0] sk_q [0:r];
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            for (int i = 0; i <= r; i++) sk_q[i] <= '0;
         end else begin
            sk_q[0] <= accept ? $signed(in_data[r*DATA_W +: DATA_W]) : '0;
            for (int i = 1; i <= r; i++) sk_q[i] <= sk_q[i-1];
         end
      end
      assign skew_out[r] = sk_q[r];
   end

   for (genvar r = 0; r < ROWS; r++) begin : g_row
      for (genvar c = 0; c < COLS; c++) begin : g_col
         logic signed [DATA_W-1:0]   w_q, a_q, a_in;
         logic signed [ACC_W-1:0]    p_q, p_in;
         logic signed [2*DATA_W-1:0] prod;

         if (c == 0) begin : g_west_edge
            assign a_in = skew_out[r];
         end else begin : g_west_pe
            assign a_in = act_w[r][c-1];
         end
         if (r == 0) begin : g_north_edge
            assign p_in = '0;
         end else begin : g_north_pe
            assign p_in = psum_w[r-1][c];
         end

         assign prod = a_in * w_q;

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               w_q <= '0;
               a_q <= '0;
               p_q <= '0;
            end else begin
               if (wt_we && wt_row == RW'(r))
                  w_q <= $signed(wt_data[c*DATA_W +: DATA_W]);
               a_q <= a_in;
               p_q <= add_acc(p_in, ACC_W'(prod));
            end
         end

         assign act_w[r][c]  = a_q;
         assign psum_w[r][c] = p_q;
      end
   end

   // Column c leaves the array c cycles after column 0; pad the early columns to line them up.
   for (genvar c = 0; c < COLS; c++) begin : g_deskew
      localparam int D = COLS - 1 - c;
      if (D == 0) begin : g_pass
         assign col_out[c] = psum_w[ROWS-1][c];
      end else begin : g_delay
         logic signed [ACC_W-1:0] dk_q [0:D-1];
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               for (int i = 0; i < D; i++) dk_q[i] <= '0;
            end else begin
               dk_q[0] <= psum_w[ROWS-1][c];
               for (int i = 1; i < D; i++) dk_q[i] <= dk_q[i-1];
            end
         end
         assign col_out[c] = dk_q[D-1];
      end
   end

   assign out_valid = vld_q[L];
   assign out_last  = last_q[L];
   assign out_data  = out_q;

endmodule

// File: tb/tb_systolic_array_ws.sv
// tb/tb_systolic_array_ws.sv - scoreboard bench for systolic_array_ws (3x3/32-bit plus 3x3/16-bit instance)
`timescale 1ns/1ps
module tb_systolic_array_ws;

   localparam int L = 6;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, wt_valid, in_valid, in_last;
   logic [23:0] wt_data, in_data;
   logic        wt_ready, in_ready, out_valid, out_last, busy;
   logic [95:0] out_data;

   logic        s_wt_valid, s_in_valid, s_in_last;
   logic [23:0] s_wt_data, s_in_data;
   logic        s_wt_ready, s_in_ready, s_out_valid, s_out_last, s_busy;
   logic [47:0] s_out_data;

   systolic_array_ws #(.ROWS(3), .COLS(3), .DATA_W(8), .ACC_W(32)) u_dut (
      .clk(clk), .rst(rst),
      .wt_valid(wt_valid), .wt_ready(wt_ready), .wt_data(wt_data),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .busy(busy)
   );

   systolic_array_ws #(.ROWS(3), .COLS(3), .DATA_W(8), .ACC_W(16)) u_dut16 (
      .clk(clk), .rst(rst),
      .wt_valid(s_wt_valid), .wt_ready(s_wt_ready), .wt_data(s_wt_data),
      .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data), .in_last(s_in_last),
      .out_valid(s_out_valid), .out_data(s_out_data), .out_last(s_out_last), .busy(s_busy)
   );

   typedef struct {
      logic [95:0] data;
      logic        last;
      int          cyc;
   } exp_t;

   exp_t             exp_q[$];
   logic signed [7:0] tb_w [3][3];
   int               checks = 0;
   int               fails  = 0;
   int               cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [95:0] model(input logic [23:0] d);
      logic [95:0] res;
      longint      acc;
      for (int c = 0; c < 3; c++) begin
         acc = 0;
         for (int r = 0; r < 3; r++)
            acc += longint'($signed(d[r*8 +: 8])) * longint'(tb_w[r][c]);
         res[c*32 +: 32] = acc[31:0];
      end
      return res;
   endfunction

   task automatic load_w(input int start_row, input logic gap);
      for (int r = start_row; r < 3; r++) begin
         wt_valid = 1'b1;
         wt_data  = {tb_w[r][2], tb_w[r][1], tb_w[r][0]};
         #1;
         for (int k = 0; k < 20 && !wt_ready; k++) begin @(negedge clk); #1; end
         @(posedge clk);
         @(negedge clk);
         wt_valid = 1'b0;
         if (gap && r == 0) @(negedge clk);
      end
   endtask

   task automatic drive_in(input logic [23:0] d, input logic last, input logic push);
      exp_t e;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      #1;
      for (int k = 0; k < 20 && !in_ready; k++) begin @(negedge clk); #1; end
      if (!in_ready) begin
         checks++; fails++;
         $display("FAIL drive_in_ready got in_ready=%b want 1", in_ready);
      end
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (push) begin
         e.data = model(d);
         e.last = last;
         e.cyc  = cyc + L;
         exp_q.push_back(e);
      end
   endtask

   task automatic test_reset;
      rst = 1'b0;
      wt_valid = 0; wt_data = '0; in_valid = 0; in_data = '0; in_last = 0;
      s_wt_valid = 0; s_wt_data = '0; s_in_valid = 0; s_in_data = '0; s_in_last = 0;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if ({wt_ready, in_ready, out_valid, out_last, busy} !== 5'b10000) begin
         fails++;
         $display("FAIL reset_ctrl got %b want 10000", {wt_ready, in_ready, out_valid, out_last, busy});
      end
      checks++;
      if (out_data !== 96'd0) begin
         fails++; $display("FAIL reset_data got %h want 0", out_data);
      end
      checks++;
      if ({s_wt_ready, s_in_ready, s_out_valid, s_busy} !== 4'b1000 || s_out_data !== 48'd0) begin
         fails++; $display("FAIL reset_dut16 got %b %h want 1000 0", {s_wt_ready, s_in_ready, s_out_valid, s_busy}, s_out_data);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_identity_back_to_back;
      exp_t e;
      for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) tb_w[r][c] = (r == c) ? 8'sd1 : 8'sd0;
      load_w(0, 1'b1);
      #1;
      checks++;
      if ({wt_ready, in_ready, busy} !== 3'b110) begin
         fails++; $display("FAIL ident_armed got %b want 110", {wt_ready, in_ready, busy});
      end
      drive_in({8'd3, 8'd2, 8'd1}, 1'b0, 1'b1);
      drive_in({8'd6, 8'd5, 8'd4}, 1'b1, 1'b1);
      #1;
      checks++;
      if ({wt_ready, in_ready, busy} !== 3'b001) begin
         fails++; $display("FAIL ident_drain got %b want 001", {wt_ready, in_ready, busy});
      end
      for (int k = 0; k < 40 && exp_q.size() > 0; k++) begin
         @(negedge clk);
         if (out_valid) begin
            e = exp_q.pop_front();
            checks++;
            if (out_data !== e.data || out_last !== e.last || cyc !== e.cyc) begin
               fails++;
               $display("FAIL ident_out got %h last=%b cyc=%0d want %h last=%b cyc=%0d", out_data, out_last, cyc, e.data, e.last, e.cyc);
            end
         end
      end
      checks++;
      if (exp_q.size() != 0) begin
         fails++; $display("FAIL ident_timeout got %0d pending want 0", exp_q.size()); exp_q.delete();
      end
      #1;
      checks++;
      if ({wt_ready, in_ready, busy} !== 3'b110) begin
         fails++; $display("FAIL ident_rearmed got %b want 110", {wt_ready, in_ready, busy});
      end
   endtask

   task automatic test_negative;
      exp_t e;
      for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) tb_w[r][c] = -8'sd1;
      @(negedge clk);
      load_w(0, 1'b0);
      drive_in({3{8'h80}}, 1'b1, 1'b1);
      for (int k = 0; k < 40 && exp_q.size() > 0; k++) begin
         @(negedge clk);
         if (out_valid) begin
            e = exp_q.pop_front();
            checks++;
            if (out_data !== e.data || out_last !== e.last || cyc !== e.cyc) begin
               fails++;
               $display("FAIL neg_out got %h last=%b cyc=%0d want %h last=%b cyc=%0d", out_data, out_last, cyc, e.data, e.last, e.cyc);
            end
         end
      end
      checks++;
      if (exp_q.size() != 0) begin
         fails++; $display("FAIL neg_timeout got %0d pending want 0", exp_q.size()); exp_q.delete();
      end
   endtask

   task automatic test_bubble;
      exp_t        e;
      int          hold_cyc;
      logic [95:0] hold_data;
      for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) tb_w[r][c] = 8'sd1;
      load_w(0, 1'b0);
      drive_in({3{8'd1}}, 1'b0, 1'b1);
      @(negedge clk);
      drive_in({3{8'd2}}, 1'b1, 1'b1);
      hold_cyc  = exp_q[0].cyc + 1;
      hold_data = exp_q[0].data;
      for (int k = 0; k < 40 && exp_q.size() > 0; k++) begin
         @(negedge clk);
         if (out_valid) begin
            e = exp_q.pop_front();
            checks++;
            if (out_data !== e.data || out_last !== e.last || cyc !== e.cyc) begin
               fails++;
               $display("FAIL bubble_out got %h last=%b cyc=%0d want %h last=%b cyc=%0d", out_data, out_last, cyc, e.data, e.last, e.cyc);
            end
         end else if (cyc == hold_cyc) begin
            checks++;
            if (out_data !== hold_data) begin
               fails++; $display("FAIL bubble_hold got %h want %h", out_data, hold_data);
            end
         end
      end
      checks++;
      if (exp_q.size() != 0) begin
         fails++; $display("FAIL bubble_timeout got %0d pending want 0", exp_q.size()); exp_q.delete();
      end
   endtask

   task automatic test_reload;
      exp_t e;
      for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) tb_w[r][c] = (r == c) ? 8'sd2 : 8'sd0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = {3{8'd9}};
      wt_valid = 1'b1;
      wt_data  = {tb_w[0][2], tb_w[0][1], tb_w[0][0]};
      #1;
      checks++;
      if ({wt_ready, in_ready} !== 2'b10) begin
         fails++; $display("FAIL reload_priority got %b want 10", {wt_ready, in_ready});
      end
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      wt_valid = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
         fails++; $display("FAIL reload_load got busy=%b in_ready=%b want 1 0", busy, in_ready);
      end
      load_w(1, 1'b0);
      drive_in({8'hF9, 8'h00, 8'h07}, 1'b0, 1'b1);
      wt_valid = 1'b1;
      wt_data  = {3{8'h55}};
      #1;
      checks++;
      if (wt_ready !== 1'b0 || busy !== 1'b1) begin
         fails++; $display("FAIL reload_stream_wt got wt_ready=%b busy=%b want 0 1", wt_ready, busy);
      end
      drive_in({3{8'd1}}, 1'b1, 1'b1);
      wt_valid = 1'b0;
      for (int k = 0; k < 40 && exp_q.size() > 0; k++) begin
         @(negedge clk);
         if (out_valid) begin
            e = exp_q.pop_front();
            checks++;
            if (out_data !== e.data || out_last !== e.last || cyc !== e.cyc) begin
               fails++;
               $display("FAIL reload_out got %h last=%b cyc=%0d want %h last=%b cyc=%0d", out_data, out_last, cyc, e.data, e.last, e.cyc);
            end
         end
      end
      checks++;
      if (exp_q.size() != 0) begin
         fails++; $display("FAIL reload_timeout got %0d pending want 0", exp_q.size()); exp_q.delete();
      end
   endtask

   task automatic test_saturate;
      int          acc;
      logic        seen;
      logic [15:0] want;
`ifdef SA_SATURATE_EN
      want = 16'h7FFF;
`else
      want = 16'hBD03;
`endif
      for (int r = 0; r < 3; r++) begin
         s_wt_valid = 1'b1;
         s_wt_data  = {3{8'd127}};
         @(posedge clk);
         @(negedge clk);
      end
      s_wt_valid = 1'b0;
      s_in_valid = 1'b1;
      s_in_data  = {3{8'd127}};
      s_in_last  = 1'b1;
      #1;
      checks++;
      if (s_in_ready !== 1'b1) begin
         fails++; $display("FAIL sat_ready got %b want 1", s_in_ready);
      end
      @(posedge clk);
      @(negedge clk);
      acc = cyc;
      s_in_valid = 1'b0;
      s_in_last  = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         if (s_out_valid) begin
            seen = 1'b1;
            checks++;
            if (s_out_data !== {3{want}} || s_out_last !== 1'b1 || cyc !== acc + L) begin
               fails++;
               $display("FAIL sat_out got %h last=%b cyc=%0d want %h last=1 cyc=%0d", s_out_data, s_out_last, cyc, {3{want}}, acc + L);
            end
         end
      end
      checks++;
      if (!seen) begin
         fails++; $display("FAIL sat_timeout got no out_valid want 1");
      end
   endtask

   task automatic test_reset_mid_stream;
      drive_in({3{8'd3}}, 1'b0, 1'b0);
      in_valid = 1'b1;
      in_data  = {3{8'd4}};
      #3;
      rst = 1'b0;
      #1;
      checks++;
      if ({out_valid, out_last, busy, wt_ready, in_ready} !== 5'b00010 || out_data !== 96'd0) begin
         fails++;
         $display("FAIL midreset_async got %b %h want 00010 0", {out_valid, out_last, busy, wt_ready, in_ready}, out_data);
      end
      @(negedge clk);
      rst = 1'b1;
      in_last = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         #1;
         checks++;
         if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL midreset_noaccept got in_ready=%b out_valid=%b busy=%b want 0 0 0", in_ready, out_valid, busy);
         end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      checks++;
      if (wt_ready !== 1'b1) begin
         fails++; $display("FAIL midreset_idle got wt_ready=%b want 1", wt_ready);
      end
   endtask

   initial begin
      test_reset;
      test_identity_back_to_back;
      test_negative;
      test_bubble;
      test_reload;
      test_saturate;
      test_reset_mid_stream;
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
